// File: rtl/alu_shift_sequencer_if.sv
// Request/response bundle between a requester and alu_shift_sequencer.
interface alu_shift_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_funct;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_result;
  logic             resp_zero;

  modport master (
    output req_valid, req_funct, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_zero
  );

  modport slave (
    input  req_valid, req_funct, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_result, resp_zero
  );
endinterface

// File: rtl/alu_shift_sequencer.sv
// Front-end controller for the 32-bit ALU: single-pass ops run once,
// multi-bit shifts are sequenced as repeated 1-bit ALU passes.
module alu_shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_shift_sequencer_if.slave bus,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [3:0]           alu_funct,
  input  logic [WIDTH-1:0]     alu_out,
  input  logic                 alu_flagZ
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EXEC  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [3:0] F_SLA = 4'b0110;
  localparam logic [3:0] F_SRA = 4'b0111;
  localparam logic [3:0] F_SRL = 4'b1000;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       funct_q, funct_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             accept;

  function automatic logic is_shift(input logic [3:0] f);
    return (f == F_SLA) || (f == F_SRA) || (f == F_SRL);
  endfunction

  // Idle indication is gated by rst_n so nothing is accepted while held in reset.
  assign bus.req_ready   = (state_q == IDLE) && rst_n;
  assign accept          = bus.req_valid && bus.req_ready;
  assign bus.resp_valid  = (state_q == DONE);
  assign bus.resp_result = result_q;
  assign bus.resp_zero   = zero_q;

  // Drive the ALU only while a pass is in flight; zero otherwise.
  always_comb begin
    alu_a     = '0;
    alu_b     = '0;
    alu_funct = '0;
    if (state_q == EXEC) begin
      alu_a     = acc_q;
      // A zero-amount shift lands here; force B to 0 so the ALU returns A.
      alu_b     = is_shift(funct_q) ? '0 : b_q;
      alu_funct = funct_q;
    end else if (state_q == SHIFT) begin
      alu_a     = acc_q;
      alu_b     = {{(WIDTH-1){1'b0}}, 1'b1};
      alu_funct = funct_q;
    end
  end

  // Next-state and datapath updates for the sequencer.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    b_d      = b_q;
    funct_d  = funct_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          funct_d = bus.req_funct;
          acc_d   = bus.req_a;
          b_d     = bus.req_b;
          cnt_d   = bus.req_b[CNT_W-1:0];
          state_d = (is_shift(bus.req_funct) && (bus.req_b[CNT_W-1:0] != '0))
                    ? SHIFT : EXEC;
        end
      end
      EXEC: begin
        result_d = alu_out;
        zero_d   = alu_flagZ;
        state_d  = DONE;
      end
      SHIFT: begin
        acc_d = alu_out;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          result_d = alu_out;
          zero_d   = alu_flagZ;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      b_q      <= '0;
      funct_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      funct_q  <= funct_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Self-checking bench for alu_shift_sequencer with a behavioural ALU and
// a whole-operation reference model.
module tb_alu_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_funct;
  logic        alu_flagZ;
  int          n_tests = 0;
  int          n_fail  = 0;

  alu_shift_sequencer_if #(.WIDTH(32)) bus ();

  alu_shift_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_funct (alu_funct),
    .alu_out   (alu_out),
    .alu_flagZ (alu_flagZ)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: shifts by the full B value, so a stray B is visible.
  always_comb begin
    case (alu_funct)
      4'b0000: alu_out = alu_a + alu_b;
      4'b0001: alu_out = alu_a - alu_b;
      4'b0010: alu_out = alu_a & alu_b;
      4'b0011: alu_out = alu_a | alu_b;
      4'b0100: alu_out = alu_a ^ alu_b;
      4'b0101: alu_out = ~alu_a;
      4'b0110: alu_out = alu_a << alu_b;
      4'b0111: alu_out = $signed(alu_a) >>> alu_b;
      4'b1000: alu_out = alu_a >> alu_b;
      default: alu_out = '0;
    endcase
    alu_flagZ = (alu_out == 32'd0);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic shift_op(input logic [3:0] f);
    return (f == 4'b0110) || (f == 4'b0111) || (f == 4'b1000);
  endfunction

  // Whole-operation result: one arithmetic expression per function.
  function automatic logic [31:0] ref_result(input logic [3:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    int n;
    n = int'(b[4:0]);
    case (f)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a & b;
      4'b0011: return a | b;
      4'b0100: return a ^ b;
      4'b0101: return ~a;
      4'b0110: return a << n;
      4'b0111: return $signed(a) >>> n;
      4'b1000: return a >> n;
      default: return 32'd0;
    endcase
  endfunction

  task automatic issue(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    int waitc;
    waitc = 0;
    while (bus.req_ready !== 1'b1 && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    check_eq("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_funct = f;
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_a     = $urandom;
    bus.req_b     = $urandom;
  endtask

  task automatic run_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    logic [31:0] er;
    int          n, el, lat, bad;
    er  = ref_result(f, a, b);
    n   = int'(b[4:0]);
    el  = (shift_op(f) && n != 0) ? n : 1;
    issue(f, a, b);
    lat = 0;
    bad = 0;
    while (bus.resp_valid !== 1'b1 && lat < 40) begin
      if (shift_op(f) && n != 0) begin
        if (alu_b !== 32'd1 || alu_funct !== f) bad++;
      end else if (alu_a !== a || alu_funct !== f) begin
        bad++;
      end
      @(posedge clk); #1;
      lat++;
    end
    check_eq("latency", 32'(lat), 32'(el));
    check_eq("alu_drive", 32'(bad), 32'd0);
    check_eq("result", bus.resp_result, er);
    check_eq("zero", 32'(bus.resp_zero), 32'(er == 32'd0));
    check_eq("req_ready_busy", 32'(bus.req_ready), 32'd0);
    check_eq("alu_quiet", alu_a | alu_b | 32'(alu_funct), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq("hold_valid", 32'(bus.resp_valid), 32'd1);
      check_eq("hold_result", bus.resp_result, er);
      check_eq("hold_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check_eq("resp_drop", 32'(bus.resp_valid), 32'd0);
    check_eq("back_idle", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_funct  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;

    #12;
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check_eq("rst_result", bus.resp_result, 32'd0);
    check_eq("rst_zero", 32'(bus.resp_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;

    // Directed cases from the operating corners.
    run_op(4'b0000, 32'd5, 32'hFFFF_FFFD, 0);
    run_op(4'b0001, 32'd7, 32'd7, 0);
    run_op(4'b0110, 32'd1, 32'd31, 0);
    run_op(4'b0111, 32'h8000_0000, 32'd4, 0);
    run_op(4'b1000, 32'h8000_0000, 32'd4, 0);
    run_op(4'b0110, 32'h1234_5678, 32'h20, 0);
    run_op(4'b0111, 32'h8765_4321, 32'hFFE0, 0);
    run_op(4'b1111, 32'd9, 32'd3, 0);
    run_op(4'b0101, 32'hFFFF_FFFF, 32'd0, 0);
    run_op(4'b0010, 32'hF0F0_1234, 32'hFFFF_0000, 5);

    // Randomized operations with random consumer back-pressure.
    for (int k = 0; k < 60; k++) begin
      logic [3:0]  f;
      logic [31:0] a, b;
      f = (k % 3 == 0) ? 4'($urandom_range(6, 8)) : 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if (k % 7 == 0) b = a;
      run_op(f, a, b, int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a 10-pass shift.
    issue(4'b1000, 32'hFFFF_0000, 32'd10);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", 32'(bus.resp_valid), 32'd0);
    check_eq("midrst_result", bus.resp_result, 32'd0);
    check_eq("midrst_ready", 32'(bus.req_ready), 32'd0);
    check_eq("midrst_alu", alu_a | alu_b | 32'(alu_funct), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rel_ready", 32'(bus.req_ready), 32'd1);
    check_eq("rel_valid", 32'(bus.resp_valid), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("no_stale_valid", 32'(bus.resp_valid), 32'd0);
    end
    run_op(4'b0100, 32'hAAAA_5555, 32'h0F0F_0F0F, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
